// File: rtl/rtc_cal_core.sv
// rtc_cal_core: time-of-day plus leap-year calendar with a prescaler and checked single-cycle field loads.
// Define RTC_ALARM_EN to add an hr/min alarm that is loaded through fields 6 and 7.
module rtc_cal_core #(
    parameter int CLK_HZ   = 100000000,
    parameter int FAST_DIV = 1000,
    parameter int PRE_W    = 27
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       run_en,
    input  logic       fast_mode,
    input  logic       set_valid,
    input  logic [2:0] set_field,
    input  logic [6:0] set_value,
`ifdef RTC_ALARM_EN
    input  logic       alarm_arm,
    output logic       alarm_hit,
`endif
    output logic       set_ack,
    output logic       set_err,
    output logic       tick_1Hz,
    output logic       end_of_day,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year
);
    localparam logic [PRE_W-1:0] TC_SLOW = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] TC_FAST = PRE_W'(CLK_HZ / FAST_DIV - 1);

    function automatic logic [4:0] dim(input logic [3:0] m, input logic [6:0] y);
        return m == 4'd2 ? (y[1:0] == 2'd0 ? 5'd29 : 5'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    logic [PRE_W-1:0] pre, tc;
    logic             fast_q, defer, tick_due, in_rng, ld_ok, step;
    logic             sec_w, min_c, hr_c, day_c, mon_c;
    logic [4:0]       dim_cur, dim_ld, day_cl, hr_s, day_s;
    logic [5:0]       sec_s, min_s;
    logic [3:0]       mon_s;
    logic [6:0]       yr_s;
`ifdef RTC_ALARM_EN
    logic [4:0]       al_hr;
    logic [5:0]       al_min;
`endif

    always_comb begin
        tc       = fast_mode ? TC_FAST : TC_SLOW;
        tick_due = run_en && fast_mode == fast_q && pre == tc;
        dim_cur  = dim(month, year);
        in_rng   = set_field == 3'd0 || set_field == 3'd1 ? set_value <= 7'd59 :
                   set_field == 3'd2 ? set_value <= 7'd23 :
                   set_field == 3'd3 ? set_value != 7'd0 && set_value <= {2'b00, dim_cur} :
                   set_field == 3'd4 ? set_value != 7'd0 && set_value <= 7'd12 :
                   set_field == 3'd5 ? set_value <= 7'd99 :
`ifdef RTC_ALARM_EN
                   set_field == 3'd6 ? set_value <= 7'd23 : set_value <= 7'd59;
`else
                   1'b0;
`endif
        ld_ok    = set_valid && in_rng;
        // a committing load wins the cycle; any due tick is replayed next cycle
        step     = (tick_due || defer) && !ld_ok;
        dim_ld   = dim(set_field == 3'd4 ? set_value[3:0] : month, set_field == 3'd5 ? set_value : year);
        day_cl   = day > dim_ld ? dim_ld : day;
        sec_w    = sec == 6'd59;
        min_c    = sec_w && min == 6'd59;
        hr_c     = min_c && hr == 5'd23;
        day_c    = hr_c && day == dim_cur;
        mon_c    = day_c && month == 4'd12;
        sec_s    = sec_w ? 6'd0 : sec + 6'd1;
        min_s    = sec_w ? (min == 6'd59 ? 6'd0 : min + 6'd1) : min;
        hr_s     = min_c ? (hr == 5'd23 ? 5'd0 : hr + 5'd1) : hr;
        day_s    = hr_c ? (day == dim_cur ? 5'd1 : day + 5'd1) : day;
        mon_s    = day_c ? (month == 4'd12 ? 4'd1 : month + 4'd1) : month;
        yr_s     = mon_c ? (year == 7'd99 ? 7'd0 : year + 7'd1) : year;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pre        <= '0;
            fast_q     <= 1'b0;
            defer      <= 1'b0;
            set_ack    <= 1'b0;
            set_err    <= 1'b0;
            tick_1Hz   <= 1'b0;
            end_of_day <= 1'b0;
            sec        <= 6'd0;
            min        <= 6'd0;
            hr         <= 5'd0;
            day        <= 5'd1;
            month      <= 4'd1;
            year       <= 7'd0;
`ifdef RTC_ALARM_EN
            alarm_hit  <= 1'b0;
            al_hr      <= 5'd0;
            al_min     <= 6'd0;
`endif
        end else begin
            fast_q     <= fast_mode;
            set_ack    <= ld_ok;
            set_err    <= set_valid && !in_rng;
            tick_1Hz   <= step;
            end_of_day <= step && hr_c;
            defer      <= (tick_due || defer) && ld_ok;
`ifdef RTC_ALARM_EN
            alarm_hit  <= step && alarm_arm && sec_w && min_s == al_min && hr_s == al_hr;
`endif
            if (fast_mode != fast_q || (ld_ok && set_field == 3'd0))
                pre <= '0;
            else if (run_en)
                pre <= pre == tc ? '0 : pre + PRE_W'(1);
            if (ld_ok) begin
                if (set_field == 3'd0) sec <= set_value[5:0];
                if (set_field == 3'd1) min <= set_value[5:0];
                if (set_field == 3'd2) hr <= set_value[4:0];
                if (set_field == 3'd3) day <= set_value[4:0];
                if (set_field == 3'd4 || set_field == 3'd5) day <= day_cl;
                if (set_field == 3'd4) month <= set_value[3:0];
                if (set_field == 3'd5) year <= set_value;
`ifdef RTC_ALARM_EN
                if (set_field == 3'd6) al_hr <= set_value[4:0];
                if (set_field == 3'd7) al_min <= set_value[5:0];
`endif
            end else if (step) begin
                sec   <= sec_s;
                min   <= min_s;
                hr    <= hr_s;
                day   <= day_s;
                month <= mon_s;
                year  <= yr_s;
            end
        end
    end
endmodule

// File: tb/tb_rtc_cal_core.sv
// tb_rtc_cal_core: directed bench for rtc_cal_core (CLK_HZ=10, FAST_DIV=5) with a set-response scoreboard.
// Alarm checks are included when RTC_ALARM_EN is defined.
module tb_rtc_cal_core;
    logic       clk = 1'b0;
    logic       reset, run_en, fast_mode, set_valid;
    logic [2:0] set_field;
    logic [6:0] set_value;
    logic       set_ack, set_err, tick_1Hz, end_of_day;
    logic [5:0] sec, min;
    logic [4:0] hr, day;
    logic [3:0] month;
    logic [6:0] year;
`ifdef RTC_ALARM_EN
    logic       alarm_arm, alarm_hit;
`endif

    typedef struct {
        int         due;
        logic [1:0] rsp;
    } rsp_t;

    rsp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_cal_core #(.CLK_HZ(10), .FAST_DIV(5), .PRE_W(4)) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .run_en(run_en),
        .fast_mode(fast_mode),
        .set_valid(set_valid),
        .set_field(set_field),
        .set_value(set_value),
`ifdef RTC_ALARM_EN
        .alarm_arm(alarm_arm),
        .alarm_hit(alarm_hit),
`endif
        .set_ack(set_ack),
        .set_err(set_err),
        .tick_1Hz(tick_1Hz),
        .end_of_day(end_of_day),
        .sec(sec),
        .min(min),
        .hr(hr),
        .day(day),
        .month(month),
        .year(year)
    );

    // every cycle: either the scheduled {ack,err} response or silence
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            checks++;
            assert ({set_ack, set_err} === sb[0].rsp) else begin
                errors++;
                $error("FAIL set_rsp cyc=%0d observed=%b expected=%b", cyc, {set_ack, set_err}, sb[0].rsp);
            end
            sb.delete(0);
        end else begin
            checks++;
            assert ({set_ack, set_err} === 2'b00) else begin
                errors++;
                $error("FAIL set_rsp_spurious cyc=%0d observed=%b expected=00", cyc, {set_ack, set_err});
            end
        end
    end

    function automatic logic [63:0] cal(input int h, input int m, input int s, input int y, input int mo, input int d);
        return {31'd0, 5'(h), 6'(m), 6'(s), 7'(y), 4'(mo), 5'(d)};
    endfunction

    function automatic logic [63:0] cur();
        return {31'd0, hr, min, sec, year, month, day};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_f(input int f, input int v, input bit ok);
        set_field = 3'(f);
        set_value = 7'(v);
        set_valid = 1'b1;
        sb.push_back('{cyc + 1, ok ? 2'b10 : 2'b01});
        @(negedge clk);
        set_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick_1Hz) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_tick(input bit eod_exp);
        int n;
        run_en = 1'b1;
        wait_tick(n);
        run_en = 1'b0;
        check("tick_seen", 64'(n > 0), 1);
        check("end_of_day", end_of_day, eod_exp);
    endtask

    initial begin
        int n;
        reset = 1'b1; run_en = 1'b0; fast_mode = 1'b0; set_valid = 1'b0; set_field = '0; set_value = '0;
`ifdef RTC_ALARM_EN
        alarm_arm = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_cal", cur(), cal(0, 0, 0, 0, 1, 1));
        check("reset_pulses", {tick_1Hz, end_of_day, set_ack, set_err}, 0);
        reset = 1'b0;
        run_en = 1'b1;
        wait_tick(n); check("first_tick", n, 10);
        wait_tick(n); check("tick_period", n, 10);
        fast_mode = 1'b1;
        wait_tick(n); check("fast_first", n, 3);
        wait_tick(n); check("fast_period", n, 2);
        fast_mode = 1'b0;
        run_en = 1'b0;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            n += int'(tick_1Hz);
        end
        check("frozen_no_tick", n, 0);

        set_f(2, 23, 1); set_f(1, 59, 1); set_f(0, 59, 1);
        set_f(3, 31, 1); set_f(4, 12, 1); set_f(5, 99, 1);
        run_tick(1);
        check("century_wrap", cur(), cal(0, 0, 0, 0, 1, 1));

        set_f(5, 3, 1); set_f(4, 2, 1); set_f(3, 28, 1);
        set_f(2, 23, 1); set_f(1, 59, 1); set_f(0, 59, 1);
        run_tick(1);
        check("feb28_y03", cur(), cal(0, 0, 0, 3, 3, 1));
        set_f(5, 4, 1); set_f(4, 2, 1); set_f(3, 28, 1);
        set_f(2, 23, 1); set_f(1, 59, 1); set_f(0, 59, 1);
        run_tick(1);
        check("feb28_y04", cur(), cal(0, 0, 0, 4, 2, 29));
        set_f(2, 23, 1); set_f(1, 59, 1); set_f(0, 59, 1);
        run_tick(1);
        check("feb29_y04", cur(), cal(0, 0, 0, 4, 3, 1));

        set_f(0, 60, 0);
        check("sec_60_kept", sec, 0);
        set_f(4, 2, 1); set_f(3, 30, 0);
        check("feb30_kept", day, 1);
`ifdef RTC_ALARM_EN
        set_f(6, 24, 0); set_f(7, 5, 1);
`else
        set_f(7, 5, 0); set_f(6, 3, 0);
`endif
        set_f(4, 13, 0); set_f(4, 0, 0); set_f(2, 24, 0);
        check("bad_loads_state", cur(), cal(0, 0, 0, 4, 2, 1));

        set_f(5, 1, 1); set_f(4, 3, 1); set_f(3, 31, 1); set_f(4, 2, 1);
        check("clamp_feb", cur(), cal(0, 0, 0, 1, 2, 28));
        set_f(4, 3, 1); set_f(3, 31, 1); set_f(4, 4, 1);
        check("clamp_apr", cur(), cal(0, 0, 0, 1, 4, 30));
        set_f(5, 4, 1); set_f(4, 2, 1); set_f(3, 29, 1); set_f(5, 5, 1);
        check("clamp_year", cur(), cal(0, 0, 0, 5, 2, 28));

        run_en = 1'b1;
        wait_tick(n); check("pre_collision_tick", 64'(n > 0), 1);
        repeat (9) @(negedge clk);
        set_f(0, 10, 1);
        check("collision_load", {tick_1Hz, sec}, {1'b0, 6'd10});
        @(negedge clk);
        check("deferred_tick", {tick_1Hz, sec}, {1'b1, 6'd11});
        run_en = 1'b0;

`ifdef RTC_ALARM_EN
        set_f(6, 7, 1); set_f(7, 30, 1);
        alarm_arm = 1'b1;
        set_f(2, 7, 1); set_f(1, 29, 1); set_f(0, 59, 1);
        run_tick(0);
        check("alarm_hit", alarm_hit, 1);
        check("alarm_time", {hr, min, sec}, {5'd7, 6'd30, 6'd0});
        @(negedge clk);
        check("alarm_single", alarm_hit, 0);
        alarm_arm = 1'b0;
        set_f(1, 29, 1); set_f(0, 59, 1);
        run_tick(0);
        check("alarm_disarmed", alarm_hit, 0);
`endif

        run_en = 1'b1;
        set_f(1, 45, 1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset", cur(), cal(0, 0, 0, 0, 1, 1));
        @(negedge clk);
        check("reset_pulses2", {tick_1Hz, end_of_day, set_ack, set_err}, 0);
        reset = 1'b0;
        wait_tick(n); check("tick_after_reset", n, 10);
        run_en = 1'b0;
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_cal_core.md
Name: rtc_cal_core

Overview:
Parametrised clock and calendar core that merges the time-of-day counter and the date counter into one block. Its prescaler is generic in clock frequency, and fast-run uses a configurable divisor. It keeps full leap-year day/month/year tracking and has a single-cycle field-load handshake with range checking. It sits under the board top level, between the button/switch decode logic and the seven-segment display mux.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz; prescaler terminal count is CLK_HZ-1.
FAST_DIV, 1000, speed-up factor in fast mode; terminal count is CLK_HZ/FAST_DIV-1, and must be ≥2 after division.
PRE_W, 27, prescaler width; must satisfy 2^PRE_W > CLK_HZ.

Ports:
clk_100MHz  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
run_en  in  1  1 = time advances; 0 = prescaler and all counters frozen.
fast_mode  in  1  1 = tick every CLK_HZ/FAST_DIV cycles.
set_valid  in  1  field-load request, one cycle.
set_field  in  3  field select: 0 sec, 1 min, 2 hr, 3 day, 4 month, 5 year, 6/7 see Optional Feature.
set_value  in  7  binary value to load.
set_ack  out  1  pulse: load accepted.
set_err  out  1  pulse: load rejected.
tick_1Hz  out  1  one-cycle pulse per time step.
end_of_day  out  1  one-cycle pulse when 23:59:59 rolls to 00:00:00.
sec  out  6  0..59.
min  out  6  0..59.
hr  out  5  0..23.
day  out  5  1..31.
month  out  4  1..12.
year  out  7  0..99; denotes 2000..2099.

Behaviour:
- Reset values: all outputs are 0, except day=1 and month=1. The prescaler is 0.
- Prescaler:
  - Counts only while run_en=1.
  - At terminal count it wraps to 0 and asserts tick_1Hz on the next cycle, registered.
  - Any change of fast_mode clears the prescaler to 0 in the same cycle.
- Tick step:
  - Counters update in the same cycle tick_1Hz is high, as a full ripple: sec→min→hr→day→month→year.
  - 59→0 carries to the next field; hr 23→0 carries and asserts end_of_day together with tick_1Hz.
- Date rollover:
  - Month lengths are 31/28/31/30/31/30/31/31/30/31/30/31.
  - Feb has 29 days when year[1:0]==0; year 0 (2000) is a leap year.
  - Day rolls to 1 and month increments; Dec 31 rolls to Jan 1 with year+1.
  - Year 99 wraps to 0.
- Set handshake:
  - set_valid is sampled on the rising edge. The result appears one cycle later: set_ack or set_err high for exactly one cycle, never both.
  - A new request is accepted every cycle, fully pipelined.
  - Valid ranges: sec/min 0..59, hr 0..23, month 1..12, year 0..99, and day 1..days_in_month(current month, current year).
  - Out-of-range value or field 6/7 (without the macro) → set_err, no state change.
- Set side effects:
  - A valid sec load also clears the prescaler.
  - After a valid month or year load, if day > new days_in_month, day is clamped to the last day in the same update. Example: Mar 31 with month←2, year 01 gives day 28.
- Set/tick collision: in a cycle where a load commits and a tick is due, the load commits and the tick step is deferred by exactly one cycle, applied to the post-load state. tick_1Hz is also delayed one cycle; no tick is ever lost.
- run_en=0 does not block loads.
- Reset mid-operation (any cycle, including during a pending load or deferred tick) returns every register to its reset value. Pending ack/err and the deferred tick are discarded.

Optional Feature:
Macro RTC_ALARM_EN.
- Defined:
  - Adds ports alarm_arm (in, 1) and alarm_hit (out, 1, reset 0).
  - Field 6 loads alarm hour (0..23); field 7 loads alarm minute (0..59). Both reset to 0.
  - alarm_hit pulses one cycle, coincident with tick_1Hz, when the tick produces sec=0 with hr/min equal to the alarm registers and alarm_arm=1.
- Not defined: no alarm ports or registers; fields 6/7 return set_err.

Test Plan:
CLK_HZ=10, FAST_DIV=5: run_en=1 from reset → first tick_1Hz at cycle 10, then every 10 cycles; fast_mode=1 → every 2 cycles.
Load hr=23, min=59, sec=59, day=31, month=12, year=99; tick → all time fields 0, day=1, month=1, year=0; end_of_day and tick_1Hz high in the same cycle.
year=03, Feb 28 23:59:59; tick → Mar 1. year=04 → Feb 29, then Mar 1 on the next day rollover.
Load field 0 value 60 → set_err one cycle later, sec unchanged. Load field 3 value 30 while month=2 → set_err. Load field 7 without the macro → set_err.
Day=31, month=3; load month=4 → set_ack, month=4, day=30. Load sec=10 in the cycle a tick is due → sec=10, then sec=11 one cycle later.
RTC_ALARM_EN: alarm 07:30, armed; run from 07:29:59 → alarm_hit pulses once at 07:30:00. Disarmed → no pulse. Assert reset mid-count → all outputs at reset values, day=month=1.
